// File: rtl/irda_mode_sequencer_pkg.sv
// Shared encodings for the IrDA mode sequencer: requested-mode codes, FSM
// state constants and the mode-to-datapath decode.
package irda_mode_sequencer_pkg;

    localparam logic [1:0] IRDA_MODE_SIR  = 2'b00;
    localparam logic [1:0] IRDA_MODE_MIR  = 2'b01;
    localparam logic [1:0] IRDA_MODE_MIRH = 2'b10;
    localparam logic [1:0] IRDA_MODE_FIR  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_CLEAR  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    typedef struct packed {
        logic fast;
        logic mir;
        logic mir_half;
        logic fir;
    } irda_mode_flags_t;

    function automatic irda_mode_flags_t irda_decode_mode(input logic [1:0] mode);
        irda_mode_flags_t flags;
        case (mode)
            IRDA_MODE_SIR:  flags = '{fast: 1'b0, mir: 1'b0, mir_half: 1'b0, fir: 1'b0};
            IRDA_MODE_MIR:  flags = '{fast: 1'b1, mir: 1'b1, mir_half: 1'b0, fir: 1'b0};
            IRDA_MODE_MIRH: flags = '{fast: 1'b1, mir: 1'b1, mir_half: 1'b1, fir: 1'b0};
            IRDA_MODE_FIR:  flags = '{fast: 1'b1, mir: 1'b0, mir_half: 1'b0, fir: 1'b1};
            default:        flags = '{fast: 1'b0, mir: 1'b0, mir_half: 1'b0, fir: 1'b0};
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/irda_mode_sequencer.sv
// Sequences IrDA SIR/MIR/FIR mode changes: drain TX, clear FIFOs, commit mode
// and loopback with an enable-generator reload, then settle before reporting done.
module irda_mode_sequencer
    import irda_mode_sequencer_pkg::*;
#(
    parameter int FIFO_PTR_W    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_i,
    input  logic [1:0]            req_mode_i,
    input  logic                  req_loopback_i,
    input  logic [FIFO_PTR_W:0]   txfifo_count_i,
    input  logic                  tx_busy_i,
    input  logic                  rx_busy_i,
    output logic                  fast_mode_o,
    output logic                  mir_mode_o,
    output logic                  mir_half_o,
    output logic                  fir_mode_o,
    output logic                  loopback_o,
    output logic                  tx_hold_o,
    output logic                  tx_fifo_clear_o,
    output logic                  rx_fifo_clear_o,
    output logic                  en_reload_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    // Counter preloads: DRAIN and SETTLE each count down to zero inclusive.
    localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_s;

    logic [1:0]        mode_r;
    logic              loop_r;
    irda_mode_flags_t  flags_r;

    logic [1:0]        latched_mode_r;
    logic [1:0]        latched_mode_s;
    logic              latched_loop_r;
    logic              latched_loop_s;

    logic              pend_valid_r;
    logic [1:0]        pend_mode_r;
    logic              pend_loop_r;

    logic              timeout_r;
    logic              timeout_s;
    logic              done_r;
    logic              done_s;
    logic              busy_r;
    logic              hold_r;
    logic              clear_r;
    logic              reload_r;

    logic              req_valid_s;
    logic [1:0]        req_sel_mode_s;
    logic              req_sel_loop_s;
    logic              drain_ok_s;

    // Request source: a live request is newer than anything held in the pending slot.
    always_comb begin
        req_valid_s    = req_i | pend_valid_r;
        req_sel_mode_s = pend_mode_r;
        req_sel_loop_s = pend_loop_r;
        if (req_i) begin
            req_sel_mode_s = req_mode_i;
            req_sel_loop_s = req_loopback_i;
        end else begin
            req_sel_mode_s = pend_mode_r;
            req_sel_loop_s = pend_loop_r;
        end
        drain_ok_s = (txfifo_count_i == {(FIFO_PTR_W + 1){1'b0}}) && !tx_busy_i && !rx_busy_i;
    end

    // Next-state, shared drain/settle counter and latched-request logic.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        latched_mode_s = latched_mode_r;
        latched_loop_s = latched_loop_r;
        timeout_s      = timeout_r;
        done_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_s) begin
                    if ((req_sel_mode_s == mode_r) && (req_sel_loop_s == loop_r)) begin
                        done_s = 1'b1;
                    end else begin
                        latched_mode_s = req_sel_mode_s;
                        latched_loop_s = req_sel_loop_s;
                        timeout_s      = 1'b0;
                        cnt_s          = DRAIN_LOAD;
                        state_s        = ST_DRAIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    cnt_s   = 16'd0;
                    state_s = ST_CLEAR;
                end else if (cnt_r == 16'd0) begin
                    timeout_s = 1'b1;
                    state_s   = ST_CLEAR;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            ST_CLEAR: begin
                state_s = ST_COMMIT;
            end
            ST_COMMIT: begin
                cnt_s   = SETTLE_LOAD;
                state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r == 16'd0) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                cnt_s   = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter, latched request and timeout flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            latched_mode_r <= IRDA_MODE_SIR;
            latched_loop_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            latched_mode_r <= latched_mode_s;
            latched_loop_r <= latched_loop_s;
            timeout_r      <= timeout_s;
        end
    end

    // One-deep pending slot; whatever it holds is consumed on the first IDLE cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend_valid_r <= 1'b0;
            pend_mode_r  <= IRDA_MODE_SIR;
            pend_loop_r  <= 1'b0;
        end else if (state_r != ST_IDLE) begin
            if (req_i) begin
                pend_valid_r <= 1'b1;
                pend_mode_r  <= req_mode_i;
                pend_loop_r  <= req_loopback_i;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end else begin
            pend_valid_r <= 1'b0;
        end
    end

    // Committed mode and loopback change only on the edge entering COMMIT.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mode_r  <= IRDA_MODE_SIR;
            loop_r  <= 1'b0;
            flags_r <= irda_decode_mode(IRDA_MODE_SIR);
        end else if (state_s == ST_COMMIT) begin
            mode_r  <= latched_mode_r;
            loop_r  <= latched_loop_r;
            flags_r <= irda_decode_mode(latched_mode_r);
        end else begin
            mode_r  <= mode_r;
        end
    end

    // Status and strobe outputs registered from the next state so they align with it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_r   <= 1'b0;
            hold_r   <= 1'b0;
            clear_r  <= 1'b0;
            reload_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r   <= (state_s != ST_IDLE);
            hold_r   <= (state_s != ST_IDLE);
            clear_r  <= (state_s == ST_CLEAR);
            reload_r <= (state_s == ST_COMMIT);
            done_r   <= done_s;
        end
    end

    assign fast_mode_o     = flags_r.fast;
    assign mir_mode_o      = flags_r.mir;
    assign mir_half_o      = flags_r.mir_half;
    assign fir_mode_o      = flags_r.fir;
    assign loopback_o      = loop_r;
    assign tx_hold_o       = hold_r;
    assign tx_fifo_clear_o = clear_r;
    assign rx_fifo_clear_o = clear_r;
    assign en_reload_o     = reload_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign timeout_o       = timeout_r;

endmodule

// File: tb/tb_irda_mode_sequencer.sv
// Self-checking bench for irda_mode_sequencer: table of mode requests plus
// hand-written pending-request and mid-sequence reset scenarios.
module tb_irda_mode_sequencer;

    localparam int FIFO_PTR_W    = 4;
    localparam int SETTLE_CYCLES = 16;
    localparam int DRAIN_TIMEOUT = 100;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                req_i;
    logic [1:0]          req_mode_i;
    logic                req_loopback_i;
    logic [FIFO_PTR_W:0] txfifo_count_i;
    logic                tx_busy_i;
    logic                rx_busy_i;
    logic fast_mode_o, mir_mode_o, mir_half_o, fir_mode_o, loopback_o, tx_hold_o;
    logic tx_fifo_clear_o, rx_fifo_clear_o, en_reload_o, busy_o, done_o, timeout_o;

    always #5 wb_clk_i = ~wb_clk_i;

    irda_mode_sequencer #(
        .FIFO_PTR_W(FIFO_PTR_W),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i),
        .req_mode_i(req_mode_i), .req_loopback_i(req_loopback_i),
        .txfifo_count_i(txfifo_count_i), .tx_busy_i(tx_busy_i), .rx_busy_i(rx_busy_i),
        .fast_mode_o(fast_mode_o), .mir_mode_o(mir_mode_o), .mir_half_o(mir_half_o),
        .fir_mode_o(fir_mode_o), .loopback_o(loopback_o), .tx_hold_o(tx_hold_o),
        .tx_fifo_clear_o(tx_fifo_clear_o), .rx_fifo_clear_o(rx_fifo_clear_o),
        .en_reload_o(en_reload_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [1:0] mode;
        logic       loop;
        int         block;
        int         sel;
        logic       stuck;
    } vec_t;

    vec_t        vecs[12];
    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  cur_mode;
    logic        cur_loop;
    logic        cur_timeout;

    // fast, mir, mir_half, fir
    function automatic logic [3:0] flags_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'b0000;
            2'b01:   return 4'b1100;
            2'b10:   return 4'b1110;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [11:0] pack_exp(input logic [1:0] m, input logic l, input logic busy,
                                             input logic clr, input logic rl, input logic dn,
                                             input logic to);
        return {flags_of(m), l, busy, clr, clr, rl, busy, dn, to};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {fast_mode_o, mir_mode_o, mir_half_o, fir_mode_o, loopback_o, tx_hold_o,
                tx_fifo_clear_o, rx_fifo_clear_o, en_reload_o, busy_o, done_o, timeout_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic check_vec(input string name);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty got %b expected entry", name, dut_vec());
        end else begin
            e = exp_q.pop_front();
            chk(name, {20'd0, dut_vec()}, {20'd0, e});
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0; req_mode_i = 2'b00; req_loopback_i = 1'b0;
        txfifo_count_i = 5'd0; tx_busy_i = 1'b0; rx_busy_i = 1'b0;
    endtask

    // sel picks which term holds the drain condition false: 0 fifo, 1 tx_busy, 2 rx_busy
    task automatic set_drain(input int j, input int block, input int sel, input logic stuck);
        logic blk;
        blk = stuck || (j < block);
        txfifo_count_i = (blk && sel == 0) ? 5'd3 : 5'd0;
        tx_busy_i      = blk && (stuck || sel == 1);
        rx_busy_i      = blk && (sel == 2);
    endtask

    // Full sequence expected from spec timing, offset j counted from the accepting edge.
    task automatic expect_seq(input logic [1:0] nm, input logic nl, input int block, input int sel,
                              input logic stuck, input logic drive_req,
                              input int p1, input logic [1:0] m1, input logic l1,
                              input int p2, input logic [1:0] m2, input logic l2,
                              input int stop_at, input string tag);
        int dl, dn_at;
        logic [1:0] em;
        logic el;
        dl    = stuck ? DRAIN_TIMEOUT : block + 1;
        dn_at = dl + 2 + SETTLE_CYCLES;
        if (drive_req) begin
            req_i = 1'b1; req_mode_i = nm; req_loopback_i = nl;
        end else begin
            req_i = 1'b0;
        end
        for (int j = 0; j <= dn_at; j++) begin
            em = (j >= dl + 1) ? nm : cur_mode;
            el = (j >= dl + 1) ? nl : cur_loop;
            exp_q.push_back(pack_exp(em, el, j < dn_at, j == dl, j == dl + 1, j == dn_at,
                                     (j >= dl) ? stuck : 1'b0));
            step();
            check_vec(tag);
            req_i = 1'b0;
            if (j == p1) begin
                req_i = 1'b1; req_mode_i = m1; req_loopback_i = l1;
            end else if (j == p2) begin
                req_i = 1'b1; req_mode_i = m2; req_loopback_i = l2;
            end
            set_drain(j, block, sel, stuck);
            if (j == stop_at) return;
        end
        cur_mode = nm; cur_loop = nl; cur_timeout = stuck;
        idle_inputs();
    endtask

    task automatic same_req(input logic [1:0] m, input logic l);
        req_i = 1'b1; req_mode_i = m; req_loopback_i = l;
        exp_q.push_back(pack_exp(cur_mode, cur_loop, 1'b0, 1'b0, 1'b0, 1'b1, cur_timeout));
        step();
        check_vec("same_mode_done");
        req_i = 1'b0;
        exp_q.push_back(pack_exp(cur_mode, cur_loop, 1'b0, 1'b0, 1'b0, 1'b0, cur_timeout));
        step();
        check_vec("same_mode_after");
    endtask

    task automatic idle_check(input string tag);
        exp_q.push_back(pack_exp(cur_mode, cur_loop, 1'b0, 1'b0, 1'b0, 1'b0, cur_timeout));
        step();
        check_vec(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0]  = '{2'd1, 1'b0, 0,  0, 1'b0};
        vecs[1]  = '{2'd3, 1'b0, 30, 0, 1'b0};
        vecs[2]  = '{2'd2, 1'b1, 5,  1, 1'b0};
        vecs[3]  = '{2'd0, 1'b0, 4,  2, 1'b0};
        vecs[4]  = '{2'd0, 1'b0, 0,  0, 1'b0};
        vecs[5]  = '{2'd3, 1'b0, 0,  1, 1'b1};
        vecs[6]  = '{2'd3, 1'b0, 0,  0, 1'b0};
        vecs[7]  = '{2'd1, 1'b1, 2,  1, 1'b0};
        vecs[8]  = '{2'd1, 1'b1, 0,  0, 1'b0};
        vecs[9]  = '{2'd0, 1'b1, 0,  0, 1'b0};
        vecs[10] = '{2'd3, 1'b1, 98, 0, 1'b0};
        vecs[11] = '{2'd1, 1'b0, 0,  0, 1'b0};

        idle_inputs();
        cur_mode = 2'b00; cur_loop = 1'b0; cur_timeout = 1'b0;
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
        exp_q.push_back(12'd0);
        check_vec("reset_state");
        txfifo_count_i = 5'd7;
        idle_check("idle_no_req");
        txfifo_count_i = 5'd0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].mode == cur_mode && vecs[i].loop == cur_loop) begin
                same_req(vecs[i].mode, vecs[i].loop);
            end else begin
                expect_seq(vecs[i].mode, vecs[i].loop, vecs[i].block, vecs[i].sel, vecs[i].stuck,
                           1'b1, -1, 2'b00, 1'b0, -1, 2'b00, 1'b0, -1, "table_seq");
                idle_check("table_idle_after");
            end
        end

        // MIR -> FIR with MIR-half then FIR arriving while busy; pending FIR matches commit
        expect_seq(2'd3, 1'b0, 0, 0, 1'b0, 1'b1, 5, 2'd2, 1'b0, 10, 2'd3, 1'b0, -1, "pend_same");
        exp_q.push_back(pack_exp(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step();
        check_vec("pend_same_done");
        idle_check("pend_same_idle");

        // FIR -> SIR with a differing request pended; it starts right after done
        expect_seq(2'd0, 1'b0, 0, 0, 1'b0, 1'b1, 3, 2'd1, 1'b1, -1, 2'b00, 1'b0, -1, "pend_first");
        expect_seq(2'd1, 1'b1, 1, 1, 1'b0, 1'b0, -1, 2'b00, 1'b0, -1, 2'b00, 1'b0, -1, "pend_second");
        idle_check("pend_second_idle");

        // Reset in SETTLE after a FIR commit
        expect_seq(2'd3, 1'b0, 0, 0, 1'b0, 1'b1, -1, 2'b00, 1'b0, -1, 2'b00, 1'b0, 5, "rst_pre");
        idle_inputs();
        #3;
        wb_rst_i = 1'b1;
        #1;
        exp_q.push_back(12'd0);
        check_vec("reset_mid_settle");
        step();
        step();
        wb_rst_i = 1'b0;
        cur_mode = 2'b00; cur_loop = 1'b0; cur_timeout = 1'b0;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (done_o || busy_o) bad++;
        end
        chk("no_done_after_reset", bad, 0);
        idle_check("post_reset_idle");
        expect_seq(2'd3, 1'b0, 0, 0, 1'b0, 1'b1, -1, 2'b00, 1'b0, -1, 2'b00, 1'b0, -1, "post_reset_seq");
        idle_check("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irda_mode_sequencer.md
# irda_mode_sequencer

Sequences safe transitions between IrDA SIR, MIR (full/half) and FIR operation. Software mode requests are never applied directly: the block drains the transmit path, clears both FIFOs, commits the new mode and loopback setting together with an enable-generator reload, then waits a settle period. It sits between the master control register and the mode-dependent datapath: enable generator, MIR/FIR transmitters and receivers, encoders/decoders, output mux and FIFOs.

## Interface
- FIFO_PTR_W, 4, FIFO pointer width; count width is FIFO_PTR_W+1
- SETTLE_CYCLES, 16, cycles held in SETTLE after commit (≥1)
- DRAIN_TIMEOUT, 65535, maximum cycles spent in DRAIN (≤65535, 16-bit counter)

- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  one-cycle mode change request
- req_mode_i  in  2  00 SIR, 01 MIR, 10 MIR half, 11 FIR
- req_loopback_i  in  1  requested loopback enable
- txfifo_count_i  in  FIFO_PTR_W+1  TX FIFO occupancy
- tx_busy_i  in  1  MIR/FIR transmitter mid-frame
- rx_busy_i  in  1  MIR/FIR receiver mid-frame
- fast_mode_o, mir_mode_o, mir_half_o, fir_mode_o  out  1 each  committed mode decode
- loopback_o  out  1  committed loopback enable
- tx_hold_o  out  1  blocks new frame starts while sequencing
- tx_fifo_clear_o, rx_fifo_clear_o  out  1 each  one-cycle FIFO clear
- en_reload_o  out  1  one-cycle enable-generator reload
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle completion pulse
- timeout_o  out  1  sticky: last drain ended by timeout

## Operation
- States: IDLE, DRAIN, CLEAR, COMMIT, SETTLE. All outputs registered.
- Decode: 00 → all mode outputs 0; 01 → fast, mir; 10 → fast, mir, mir_half; 11 → fast, fir.
- IDLE, req_i=1:
  - If req_mode_i/req_loopback_i equal the committed values: done_o pulses, no sequence runs.
  - Otherwise: latch the request, clear timeout_o, go to DRAIN.
- DRAIN: tx_hold_o=1. A frame already in progress completes.
  - Leave for CLEAR when txfifo_count_i==0 and !tx_busy_i and !rx_busy_i.
  - Also leave for CLEAR when the drain counter reaches DRAIN_TIMEOUT-1. On this exit timeout_o is set.
- CLEAR: tx_fifo_clear_o=rx_fifo_clear_o=1 for exactly one cycle.
- COMMIT: mode outputs and loopback_o take the latched values; en_reload_o=1 for one cycle.
- SETTLE: count SETTLE_CYCLES cycles, then go to IDLE and pulse done_o.
- busy_o=1 and tx_hold_o=1 in every state except IDLE.
- req_i while busy_o=1: stored in a one-deep pending slot; a newer request overwrites it. On return to IDLE, a pending request is processed as if req_i were high. The same-mode check applies, against the newly committed mode.
- Reset (including mid-sequence): state IDLE, SIR mode (all mode outputs 0), loopback_o=0, all pulses 0, busy_o=0, tx_hold_o=0, timeout_o=0, pending slot empty, counters 0.

## Timing
- Request sampled on edge k with drain condition already true:
  - After edge k: DRAIN, busy_o=1.
  - After edge k+1: CLEAR, FIFO clears high.
  - After edge k+2: COMMIT, new mode visible, en_reload_o high.
  - After edge k+3: SETTLE.
  - After edge k+3+SETTLE_CYCLES: IDLE, done_o high for one cycle, busy_o=0.
- A blocked drain adds one cycle per cycle the drain condition is false, up to DRAIN_TIMEOUT cycles total in DRAIN.
- Same-mode request on edge k: done_o high after edge k; busy_o stays 0.
- Pending request: accepted on the edge that follows the done_o cycle (no idle gap beyond that cycle).
- Mode outputs change only on the COMMIT edge or on reset.

## Structure
- Shared package/defines: mode encodings (IRDA_MODE_SIR/MIR/MIRH/FIR), state encoding, decode function.
- Drain/settle counter: a single 16-bit down-counter, shared because DRAIN and SETTLE are mutually exclusive. No sub-module required.

## Test plan
- Reset, then req MIR with FIFO empty and not busy → mir_mode_o=fast_mode_o=1 after edge k+2; done_o after edge k+19 (SETTLE_CYCLES=16); one clear pulse and one reload pulse.
- txfifo_count_i=3 draining to 0 over 30 cycles, then req FIR → CLEAR occurs only after count==0 and tx_busy_i=0; timeout_o=0.
- tx_busy_i stuck high, DRAIN_TIMEOUT=100 → CLEAR after 100 DRAIN cycles; timeout_o=1 until the next accepted request.
- Req SIR while in SIR with loopback unchanged → done_o one cycle later; no clear, no reload; busy_o stays 0.
- While busy (MIR→FIR sequence), req MIR half then req FIR → only the FIR request is pending; it matches the newly committed FIR, so done_o pulses with no second sequence.
- Assert wb_rst_i in SETTLE after a FIR commit → outputs immediately return to SIR with busy_o=0; no done_o after reset release.
